// File: rtl/sim_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_mmio_pkg
// Description : Shared types and default MMIO map for the simulation monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package sim_mmio_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_TIMEOUT  = 2'd1,
        FC_RANGE    = 2'd2,
        FC_OVERFLOW = 2'd3
    } fault_cause_t;

    localparam logic [31:0] c_MMIO_BASE = 32'h9000_0000;
    localparam logic [31:0] c_PUTC_OFF  = 32'h0000_001c;
    localparam logic [31:0] c_EXIT_OFF  = 32'h0000_002c;

    // A single channel still carries a 1-bit channel field.
    function automatic int chan_width(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sim_sync_fifo
// Description : Single-clock FIFO with registered flags; full FIFO accepts a
//               push when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_empty;
    logic             r_full;

    logic             w_pop;
    logic             w_push;
    logic [AW:0]      w_count_nxt;

    assign w_pop  = pop & ~r_empty;
    assign w_push = push & (~r_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rptr];
    assign empty   = r_empty;
    assign full    = r_full;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/sim_mmio_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sim_mmio_monitor
// Description : MMIO console/exit decoder with console FIFO, PC-stall timeout
//               and out-of-range write detection; halts after draining.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_mmio_monitor
    import sim_mmio_pkg::*;
#(
    parameter  logic [31:0] MMIO_BASE  = c_MMIO_BASE,
    parameter  logic [31:0] PUTC_OFF   = c_PUTC_OFF,
    parameter  logic [31:0] EXIT_OFF   = c_EXIT_OFF,
    parameter  int          NCHAN      = 1,
    parameter  int          MEM_AW     = 18,
    parameter  int          FIFO_DEPTH = 16,
    parameter  int          TIMEOUT    = 100,
    localparam int          CW         = chan_width(NCHAN)
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          wr_ready,
    input  logic [31:0]   wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    input  logic [31:0]   pc,
    output logic          mem_wready,
    output logic          tx_valid,
    output logic [CW-1:0] tx_chan,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          done,
    output logic [31:0]   exit_code,
    output logic          fault,
    output logic [1:0]    fault_cause
);

    localparam int            FAW       = $clog2(FIFO_DEPTH);
    localparam int            FW        = CW + 8;
    localparam int            TW        = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] c_TMO_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] c_TMO_SAT = TW'(TIMEOUT + 1);

    mon_state_t    r_state;
    fault_cause_t  r_cause;
    logic          r_kind_exit;
    logic          r_done;
    logic          r_fault;
    logic [31:0]   r_exit_code;
    logic [31:0]   r_pc_q;
    logic [TW-1:0] r_tmo_cnt;

    logic          w_putc_hit;
    logic [CW-1:0] w_putc_chan;
    logic          w_exit_hit;
    logic          w_mmio_hit;
    logic          w_oor;
    logic          w_wr;
    logic          w_pop;
    logic          w_putc_req;
    logic          w_push;
    logic          w_ovf;
    logic          w_tmo;
    logic          w_drained;

    logic [FW-1:0] w_fifo_rd;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [FAW:0]  w_fifo_count;
    logic          w_unused;

    always_comb begin
        w_putc_hit  = 1'b0;
        w_putc_chan = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (wr_addr == MMIO_BASE + PUTC_OFF + 32'(4 * k)) begin
                w_putc_hit  = 1'b1;
                w_putc_chan = CW'(k);
            end
        end
    end

    assign w_exit_hit = (wr_addr == MMIO_BASE + EXIT_OFF);
    assign w_mmio_hit = w_putc_hit | w_exit_hit;
    assign w_oor      = ~w_mmio_hit & (|(wr_addr >> MEM_AW));
    assign w_wr       = wr_ready & (r_state == ST_RUN);

    // Out-of-range stores never reach RAM; they only raise the fault.
    assign mem_wready = w_wr & ~w_mmio_hit & ~w_oor;

    assign w_pop      = tx_valid & tx_ready;
    assign w_putc_req = w_wr & w_putc_hit & wr_strb[0];
    assign w_push     = w_putc_req & (~w_fifo_full | w_pop);
    assign w_ovf      = w_putc_req & w_fifo_full & ~w_pop;
    assign w_tmo      = (r_state == ST_RUN) & (r_tmo_cnt > c_TMO_MAX);

    // Halt on the same edge that pops the last buffered byte.
    assign w_drained  = w_fifo_empty | ((w_fifo_count == (FAW+1)'(1)) & w_pop);

    sim_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .push    (w_push),
        .wr_data ({w_putc_chan, wr_data[7:0]}),
        .pop     (w_pop),
        .rd_data (w_fifo_rd),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full),
        .count   (w_fifo_count)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state     <= ST_RUN;
            r_cause     <= FC_NONE;
            r_kind_exit <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_exit_code <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wr && w_exit_hit) begin
                        r_exit_code <= wr_data;
                        r_kind_exit <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else if (w_wr && w_oor) begin
                        r_cause <= FC_RANGE;
                        r_state <= ST_DRAIN;
                    end else if (w_ovf) begin
                        r_cause <= FC_OVERFLOW;
                        r_state <= ST_DRAIN;
                    end else if (w_tmo) begin
                        r_cause <= FC_TIMEOUT;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= ST_HALT;
                        r_done  <= r_kind_exit;
                        r_fault <= ~r_kind_exit;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_pc_q    <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_pc_q <= pc;
            if (r_state == ST_RUN) begin
                if (pc != r_pc_q) begin
                    r_tmo_cnt <= '0;
                end else if (r_tmo_cnt != c_TMO_SAT) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign tx_valid    = ~w_fifo_empty;
    assign tx_chan     = w_fifo_rd[FW-1:8];
    assign tx_data     = w_fifo_rd[7:0];
    assign done        = r_done;
    assign fault       = r_fault;
    assign fault_cause = r_cause;
    assign exit_code   = r_exit_code;

    assign w_unused    = ^wr_strb[3:1];

endmodule
`default_nettype wire

// File: tb/tb_sim_mmio_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_mmio_monitor
// Description : Directed self-checking bench for sim_mmio_monitor
//               (two console channels, four-entry FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_mmio_monitor;

    localparam logic [31:0] c_PUTC0 = 32'h9000_001c;
    localparam logic [31:0] c_PUTC1 = 32'h9000_0020;
    localparam logic [31:0] c_EXIT  = 32'h9000_002c;

    logic        clk      = 1'b0;
    logic        resetb   = 1'b0;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic [3:0]  wr_strb  = '0;
    logic [31:0] pc       = '0;
    logic        tx_ready = 1'b0;
    logic        mem_wready;
    logic        tx_valid;
    logic [0:0]  tx_chan;
    logic [7:0]  tx_data;
    logic        done;
    logic [31:0] exit_code;
    logic        fault;
    logic [1:0]  fault_cause;

    logic        pc_run   = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rx;

    always #5 clk = ~clk;

    sim_mmio_monitor #(
        .NCHAN      (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .pc          (pc),
        .mem_wready  (mem_wready),
        .tx_valid    (tx_valid),
        .tx_chan     (tx_chan),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .done        (done),
        .exit_code   (exit_code),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_run) pc = pc + 32'd4;
    endtask

    task automatic idle();
        wr_ready = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_ready = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
    endtask

    task automatic do_reset();
        idle();
        tx_ready = 1'b0;
        pc_run   = 1'b1;
        #2 resetb = 1'b0;
        tick();
        tick();
        resetb = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cause", fault_cause, 0);
        chk("rst_exit_code", exit_code, 0);

        // "Hi" on channel 0, one cycle latency per byte
        tx_ready = 1'b1;
        wr(c_PUTC0, 32'h48, 4'h1);
        #1 chk("h_mem_wready", mem_wready, 0);
        tick();
        wr(c_PUTC0, 32'h69, 4'h1);
        #1 chk("i_mem_wready", mem_wready, 0);
        chk("h_valid", tx_valid, 1);
        chk("h_data", tx_data, 32'h48);
        tick();
        idle();
        chk("i_valid", tx_valid, 1);
        chk("i_data", tx_data, 32'h69);
        tick();
        chk("hi_empty", tx_valid, 0);
        wr(32'h0000_0100, 32'h1234, 4'hf);
        #1 chk("ram_mem_wready", mem_wready, 1);
        tick();
        wr(c_PUTC0, 32'h77, 4'b0010);
        #1 chk("nostrb_mem_wready", mem_wready, 0);
        tick();
        idle();
        chk("nostrb_no_push", tx_valid, 0);

        // Channel 1 byte held while the sink stalls
        do_reset();
        wr(c_PUTC1, 32'h41, 4'h1);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("ch1_valid", tx_valid, 1);
            chk("ch1_chan", tx_chan, 1);
            chk("ch1_data", tx_data, 32'h41);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        chk("ch1_popped", tx_valid, 0);

        // EXIT waits for the console to drain
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr(c_PUTC0, 32'h61 + i, 4'h1);
            tick();
        end
        wr(c_EXIT, 32'h2a, 4'hf);
        #1 chk("exit_mem_wready", mem_wready, 0);
        tick();
        idle();
        chk("exit_code", exit_code, 32'h2a);
        chk("exit_done_early", done, 0);
        wr(32'h0000_0100, 32'h0, 4'hf);
        #1 chk("drain_mem_wready", mem_wready, 0);
        wr(c_PUTC0, 32'h7a, 4'h1);
        tick();
        idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_data", tx_data, 32'h61 + i);
            chk("drain_done", done, 0);
            tick();
        end
        chk("exit_done", done, 1);
        chk("exit_fault", fault, 0);
        chk("drain_ignored_putc", tx_valid, 0);

        // Timeout boundary: counter at TIMEOUT is tolerated, TIMEOUT+1 faults
        do_reset();
        pc_run = 1'b0;
        pc     = 32'h0000_1000;
        repeat (101) tick();
        pc = 32'h0000_2000;
        tick();
        chk("tmo_cleared", fault_cause, 0);
        repeat (101) tick();
        chk("tmo_at_limit", fault_cause, 0);
        tick();
        chk("tmo_cause", fault_cause, 1);
        chk("tmo_fault_pending", fault, 0);
        tick();
        chk("tmo_fault", fault, 1);
        chk("tmo_done", done, 0);

        // Out-of-range write
        do_reset();
        wr(32'h0003_fffc, 32'h1, 4'hf);
        #1 chk("inrange_mem_wready", mem_wready, 1);
        tick();
        idle();
        chk("inrange_cause", fault_cause, 0);
        wr(32'h0004_0000, 32'h1, 4'hf);
        #1 chk("oor_mem_wready", mem_wready, 0);
        tick();
        idle();
        chk("oor_cause", fault_cause, 2);
        tick();
        chk("oor_fault", fault, 1);
        chk("oor_done", done, 0);

        // Overflow: fifth byte into a full FIFO is dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr(c_PUTC0, 32'h31 + i, 4'h1);
            tick();
        end
        idle();
        chk("ovf_cause", fault_cause, 3);
        chk("ovf_fault_pending", fault, 0);
        tx_ready = 1'b1;
        n_rx = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid) begin
                chk("ovf_data", tx_data, 32'h31 + n_rx);
                n_rx++;
            end
            tick();
        end
        chk("ovf_count", n_rx, 4);
        chk("ovf_fault", fault, 1);

        // Full FIFO with a same-cycle pop accepts the push
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(c_PUTC0, 32'h51 + i, 4'h1);
            tick();
        end
        wr(c_PUTC0, 32'h55, 4'h1);
        tx_ready = 1'b1;
        #1 chk("popfull_head", tx_data, 32'h51);
        tick();
        idle();
        chk("popfull_cause", fault_cause, 0);
        n_rx = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid) begin
                chk("popfull_data", tx_data, 32'h52 + n_rx);
                n_rx++;
            end
            tick();
        end
        chk("popfull_count", n_rx, 4);
        chk("popfull_fault", fault, 0);

        // Asynchronous reset mid-operation discards buffered bytes
        do_reset();
        wr(c_PUTC0, 32'h10, 4'h1);
        tick();
        wr(c_PUTC0, 32'h11, 4'h1);
        tick();
        idle();
        chk("mid_valid", tx_valid, 1);
        #2 resetb = 1'b0;
        #1 chk("mid_async_clear", tx_valid, 0);
        tick();
        resetb = 1'b1;
        tick();
        chk("mid_lost", tx_valid, 0);
        chk("mid_cause", fault_cause, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
